imem_arbiter: RTL and testbench

Arbitrates the single-port instruction memory between the instruction fetch unit (read-only) and the program loader (read/write). The loader uses it to write programs into the 2K x 16 instruction store at run time and to read them back. Fetch has priority. A bounded starvation counter guarantees the loader progress, and a lock input lets the loader own memory exclusively during a bulk program load.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_arbiter_if.sv | 39 +++
 rtl/imem_lock_fsm.sv | 35 +++
 rtl/imem_arbiter.sv | 79 +++++++
 tb/tb_imem_arbiter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared widths, lock states and read-owner encoding for the imem arbiter
package imem_pkg;
  localparam int IMEM_ADDR_W = 11;
  localparam int IMEM_DATA_W = 16;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    DRAIN    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_t;
endpackage

// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - fetch, loader and memory-side signals of the imem arbiter
interface imem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_lock;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;
  logic              locked;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, locked,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, locked,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_lock_fsm.sv
// rtl/imem_lock_fsm.sv - loader lock state machine; holds off LOCKED until fetch reads drain
module imem_lock_fsm
  import imem_pkg::*;
(
  input  logic clk,
  input  logic reset_i,
  input  logic l_lock_i,
  input  logic fetch_pending_i,
  output logic locked_o,
  output logic fetch_block_o
);
  lock_state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (!reset_i) state_q <= UNLOCKED;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED: if (l_lock_i) state_d = DRAIN;
      DRAIN: begin
        if (!l_lock_i)             state_d = UNLOCKED;
        else if (!fetch_pending_i) state_d = LOCKED;
      end
      LOCKED:   if (!l_lock_i) state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  assign locked_o = (state_q != UNLOCKED);
  // Raw l_lock blocks fetch in the rising cycle, before the state has moved.
  assign fetch_block_o = locked_o | l_lock_i;
endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - fetch-priority arbiter for the shared instruction memory with loader starvation guard and lock
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W       = IMEM_ADDR_W,
  parameter int DATA_W       = IMEM_DATA_W,
  parameter int STARVE_LIMIT = 4
)(
  input  logic           clk,
  input  logic           reset,
  imem_arbiter_if.slave  bus
);
  logic [3:0]        starve_q, starve_d;
  owner_t            own_q, own_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] l_rdata_q, l_rdata_d;
  logic [ADDR_W-1:0] addr_sel;
  logic              fetch_block, loader_force;
  logic              f_gnt, l_gnt, f_rvalid, l_rvalid, locked;

  imem_lock_fsm u_lock_fsm (
    .clk             (clk),
    .reset_i         (reset),
    .l_lock_i        (bus.l_lock),
    .fetch_pending_i (own_q == OWN_FETCH),
    .locked_o        (locked),
    .fetch_block_o   (fetch_block)
  );

  assign loader_force = (starve_q == 4'(STARVE_LIMIT)) && bus.l_req;
  assign f_gnt = reset && bus.f_req && !fetch_block && !loader_force;
  assign l_gnt = reset && bus.l_req && !f_gnt;

  assign f_rvalid = reset && (own_q == OWN_FETCH);
  assign l_rvalid = reset && (own_q == OWN_LOAD);

  always_comb begin
    starve_d  = starve_q;
    own_d     = OWN_NONE;
    f_rdata_d = f_rdata_q;
    l_rdata_d = l_rdata_q;
    addr_sel  = '0;
    if (!bus.l_req || l_gnt)                 starve_d = '0;
    else if (starve_q != 4'(STARVE_LIMIT))   starve_d = starve_q + 4'd1;
    if (f_gnt)                 own_d = OWN_FETCH;
    else if (l_gnt && !bus.l_we) own_d = OWN_LOAD;
    if (f_rvalid) f_rdata_d = bus.mem_rdata;
    if (l_rvalid) l_rdata_d = bus.mem_rdata;
    if (l_gnt)      addr_sel = bus.l_addr;
    else if (f_gnt) addr_sel = bus.f_addr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q  <= '0;
      own_q     <= OWN_NONE;
      f_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      starve_q  <= starve_d;
      own_q     <= own_d;
      f_rdata_q <= f_rdata_d;
      l_rdata_q <= l_rdata_d;
    end
  end

  assign bus.f_gnt     = f_gnt;
  assign bus.l_gnt     = l_gnt;
  assign bus.f_rvalid  = f_rvalid;
  assign bus.l_rvalid  = l_rvalid;
  // Returning data is passed through in its valid cycle and held afterwards.
  assign bus.f_rdata   = f_rvalid ? bus.mem_rdata : f_rdata_q;
  assign bus.l_rdata   = l_rvalid ? bus.mem_rdata : l_rdata_q;
  assign bus.locked    = locked;
  assign bus.mem_en    = f_gnt | l_gnt;
  assign bus.mem_we    = l_gnt & bus.l_we;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = l_gnt ? bus.l_wdata : '0;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter with a write-first memory model
module tb_imem_arbiter;
  import imem_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] mem [0:2047];

  imem_arbiter_if bus ();

  imem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous write-first single-port memory
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata     <= bus.mem_wdata;
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1234;
    mem[2] = 16'h2222;
    mem[7] = 16'h0777;
    bus.mem_rdata = 16'h0;
    reset = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 11'h0;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 11'h0; bus.l_wdata = 16'h0;
    bus.l_lock = 1'b0;

    // Reset with both requests high
    cyc(); #1;
    check("rst_f_gnt", 32'(bus.f_gnt), 0);
    check("rst_l_gnt", 32'(bus.l_gnt), 0);
    check("rst_f_rvalid", 32'(bus.f_rvalid), 0);
    check("rst_l_rvalid", 32'(bus.l_rvalid), 0);
    check("rst_mem_en", 32'(bus.mem_en), 0);
    check("rst_locked", 32'(bus.locked), 0);
    cyc(); #1;
    check("rst_f_rdata", 32'(bus.f_rdata), 0);
    check("rst_l_rdata", 32'(bus.l_rdata), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 0);

    // First fetch after release
    cyc(); reset = 1'b1; bus.l_req = 1'b0; bus.f_addr = 11'h000; #1;
    check("f0_gnt", 32'(bus.f_gnt), 1);
    check("f0_mem_en", 32'(bus.mem_en), 1);
    check("f0_mem_addr", 32'(bus.mem_addr), 32'h000);
    cyc(); bus.f_req = 1'b0; #1;
    check("f0_rvalid", 32'(bus.f_rvalid), 1);
    check("f0_rdata", 32'(bus.f_rdata), 32'h1234);
    check("f0_l_rvalid", 32'(bus.l_rvalid), 0);

    // Loader write then read-back of the same address
    cyc(); bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 11'h005; bus.l_wdata = 16'h8210; #1;
    check("lw_gnt", 32'(bus.l_gnt), 1);
    check("lw_mem_we", 32'(bus.mem_we), 1);
    check("lw_mem_wdata", 32'(bus.mem_wdata), 32'h8210);
    check("lw_mem_addr", 32'(bus.mem_addr), 32'h005);
    cyc(); bus.l_we = 1'b0; #1;
    check("lr_gnt", 32'(bus.l_gnt), 1);
    check("lr_mem_we", 32'(bus.mem_we), 0);
    check("lw_no_rvalid", 32'(bus.l_rvalid), 0);
    cyc(); bus.l_req = 1'b0; #1;
    check("lr_rvalid", 32'(bus.l_rvalid), 1);
    check("lr_rdata", 32'(bus.l_rdata), 32'h8210);
    check("lr_f_rdata_hold", 32'(bus.f_rdata), 32'h1234);
    cyc(); #1;
    check("lr_rvalid_pulse", 32'(bus.l_rvalid), 0);
    check("lr_rdata_hold", 32'(bus.l_rdata), 32'h8210);

    // Starvation: fetch wins 4 cycles, loader forced on the 5th
    cyc(); bus.f_req = 1'b1; bus.f_addr = 11'h001; bus.l_req = 1'b1; bus.l_addr = 11'h007; #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stv_f_gnt%0d", i), 32'(bus.f_gnt), 1);
      check($sformatf("stv_l_gnt%0d", i), 32'(bus.l_gnt), 0);
      cyc(); #1;
    end
    check("stv_l_forced", 32'(bus.l_gnt), 1);
    check("stv_f_denied", 32'(bus.f_gnt), 0);
    check("stv_mem_addr", 32'(bus.mem_addr), 32'h007);
    cyc(); #1;
    check("stv_cnt_clr", 32'(dut.starve_q), 0);
    check("stv_f_again", 32'(bus.f_gnt), 1);
    check("stv_l_rvalid", 32'(bus.l_rvalid), 1);
    check("stv_l_rdata", 32'(bus.l_rdata), 32'h0777);
    cyc(); bus.f_req = 1'b0; bus.l_req = 1'b0; #1;

    // Lock raised the cycle after a fetch grant
    cyc(); bus.f_req = 1'b1; bus.f_addr = 11'h002; #1;
    check("lk_f_gnt", 32'(bus.f_gnt), 1);
    cyc(); bus.l_lock = 1'b1; #1;
    check("lk_rise_f_gnt", 32'(bus.f_gnt), 0);
    check("lk_rise_f_rvalid", 32'(bus.f_rvalid), 1);
    check("lk_rise_f_rdata", 32'(bus.f_rdata), 32'h2222);
    check("lk_rise_locked", 32'(bus.locked), 0);
    cyc(); bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 11'h005; #1;
    check("lk_drain_state", 32'(dut.u_lock_fsm.state_q), 32'(DRAIN));
    check("lk_drain_locked", 32'(bus.locked), 1);
    check("lk_drain_f_gnt", 32'(bus.f_gnt), 0);
    check("lk_drain_l_gnt", 32'(bus.l_gnt), 1);
    cyc(); bus.l_req = 1'b0; #1;
    check("lk_state", 32'(dut.u_lock_fsm.state_q), 32'(LOCKED));
    check("lk_locked", 32'(bus.locked), 1);
    check("lk_f_gnt", 32'(bus.f_gnt), 0);
    check("lk_l_rvalid", 32'(bus.l_rvalid), 1);
    check("lk_l_rdata", 32'(bus.l_rdata), 32'h8210);
    cyc(); bus.l_lock = 1'b0; #1;
    check("unlk_fall_f_gnt", 32'(bus.f_gnt), 0);
    cyc(); #1;
    check("unlk_locked", 32'(bus.locked), 0);
    check("unlk_f_gnt", 32'(bus.f_gnt), 1);
    cyc(); bus.f_req = 1'b0; #1;

    // Reset between a loader read grant and its return
    cyc(); bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 11'h007; #1;
    check("rr_l_gnt", 32'(bus.l_gnt), 1);
    cyc(); reset = 1'b0; bus.l_req = 1'b0; #1;
    check("rr_no_rvalid", 32'(bus.l_rvalid), 0);
    cyc(); #1;
    check("rr_l_rvalid", 32'(bus.l_rvalid), 0);
    check("rr_l_rdata", 32'(bus.l_rdata), 0);
    check("rr_f_rdata", 32'(bus.f_rdata), 0);
    check("rr_mem_en", 32'(bus.mem_en), 0);
    check("rr_locked", 32'(bus.locked), 0);
    check("rr_owner", 32'(dut.own_q), 32'(OWN_NONE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
